flash_sequencer: RTL and testbench

FLASH_SEQUENCER -- requirements
Module: flash_sequencer

---
 rtl/bound_flasher_pkg.sv | 36 +++
 rtl/lamp_decoder.sv | 16 +
 rtl/flash_sequencer.sv | 59 +++++
 tb/tb_flash_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/bound_flasher_pkg.sv
// Shared types and constants for the bound flasher: counter command
// encoding, the sequencer state set and the lamp/counter bounds.
package bound_flasher_pkg;

    localparam int CNT_W     = 5;
    localparam int LAMP_MAX  = 16;
    localparam int BOUND_LO  = 5;
    localparam int BOUND_MID = 10;

    typedef enum logic [1:0] {
        COUNT_INIT    = 2'b00,
        COUNT_UP_EN   = 2'b01,
        COUNT_DOWN_EN = 2'b10,
        COUNT_HOLD    = 2'b11
    } count_state_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_UP1   = 3'd1,
        S_DOWN1 = 3'd2,
        S_UP2   = 3'd3,
        S_DOWN2 = 3'd4,
        S_UP3   = 3'd5,
        S_DOWN3 = 3'd6
    } state_e;

    // Counter direction implied by the state about to be entered.
    function automatic count_state_e dir_of(input state_e s);
        case (s)
            S_UP1, S_UP2, S_UP3:       dir_of = COUNT_UP_EN;
            S_DOWN1, S_DOWN2, S_DOWN3: dir_of = COUNT_DOWN_EN;
            default:                   dir_of = COUNT_INIT;
        endcase
    endfunction

endpackage

// File: rtl/lamp_decoder.sv
// Thermometer decode: lamp[i] is lit whenever the count exceeds i,
// so any out-of-range count above 16 lights every lamp.
module lamp_decoder
    import bound_flasher_pkg::*;
(
    input  logic [CNT_W-1:0]    counter,
    output logic [LAMP_MAX-1:0] lamp
);

    generate
        for (genvar gi = 0; gi < LAMP_MAX; gi++) begin : g_lamp
            assign lamp[gi] = (counter > CNT_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/flash_sequencer.sv
// Bound-flasher control FSM: steers an external counter up/down between
// bounds and supports flick kickbacks at the upper bounds of phases 2 and 3.
module flash_sequencer
    import bound_flasher_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flick,
    input  logic [CNT_W-1:0]    counter,
    output logic [1:0]          count_state,
    output logic [CNT_W-1:0]    counter_load,
    output logic                counter_load_en,
    output logic [LAMP_MAX-1:0] lamp,
    output logic                busy
);

    state_e state_q;
    state_e state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        counter_load    = '0;
        counter_load_en = 1'b0;
        if (counter > CNT_W'(LAMP_MAX)) begin
            // Corrupt count: reload zero and drop back to idle.
            counter_load_en = 1'b1;
            state_d         = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (flick) state_d = S_UP1;
                S_UP1:   if (counter == CNT_W'(LAMP_MAX)) state_d = S_DOWN1;
                S_DOWN1: if (counter == CNT_W'(BOUND_LO)) state_d = S_UP2;
                S_UP2:   if (counter == CNT_W'(BOUND_MID)) state_d = flick ? S_DOWN1 : S_DOWN2;
                S_DOWN2: if (counter == '0) state_d = S_UP3;
                S_UP3:   if (counter == CNT_W'(BOUND_LO)) state_d = flick ? S_DOWN2 : S_DOWN3;
                S_DOWN3: if (counter == '0) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Idle always commands INIT, so the first step after a flick is a dwell at 0.
    assign count_state = (state_q == S_IDLE) ? COUNT_INIT : dir_of(state_d);
    assign busy        = (state_q != S_IDLE);

    lamp_decoder u_lamp_decoder (
        .counter (counter),
        .lamp    (lamp)
    );

endmodule

// File: tb/tb_flash_sequencer.sv
// Directed bench: closes the loop with a counter register around the sequencer.
module tb_flash_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flick = 1'b0;
    logic [4:0]  counter;
    logic [1:0]  count_state;
    logic [4:0]  counter_load;
    logic        counter_load_en;
    logic [15:0] lamp;
    logic        busy;

    logic [4:0]  cnt_q;
    logic        force_en = 1'b0;
    logic [4:0]  force_val = 5'd0;

    int checks_cnt = 0;
    int errors_cnt = 0;

    always #5 clk = ~clk;

    flash_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flick           (flick),
        .counter         (counter),
        .count_state     (count_state),
        .counter_load    (counter_load),
        .counter_load_en (counter_load_en),
        .lamp            (lamp),
        .busy            (busy)
    );

    assign counter = force_en ? force_val : cnt_q;

    // External next-counter generator plus counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 5'd0;
        end else if (counter_load_en) begin
            cnt_q <= counter_load;
        end else begin
            case (count_state)
                2'b00:   cnt_q <= 5'd0;
                2'b01:   cnt_q <= counter + 5'd1;
                2'b10:   cnt_q <= counter - 5'd1;
                default: cnt_q <= counter;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Pulse flick in idle; returns in the first busy cycle.
    task automatic start_seq;
        flick = 1'b1;
        #1;
        chk("idle_flick_cs", 32'(count_state), 32'd0);
        tick();
        flick = 1'b0;
        #1;
    endtask

    task automatic wait_idle;
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    int exp_trace[$];
    int busy_cycles;
    int full_cycles;
    int peak;

    initial begin
        // Reset state
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cs", 32'(count_state), 32'd0);
        chk("rst_load_en", 32'(counter_load_en), 32'd0);
        chk("rst_lamp", 32'(lamp), 32'd0);
        rst_n = 1'b1;
        tick(); tick();
        chk("idle_cs", 32'(count_state), 32'd0);
        chk("idle_cnt", 32'(counter), 32'd0);
        $display("reset/idle checked");

        // Full sequence
        exp_trace.push_back(0);
        for (int v = 1; v <= 16; v++) exp_trace.push_back(v);
        for (int v = 15; v >= 5; v--) exp_trace.push_back(v);
        for (int v = 6; v <= 10; v++) exp_trace.push_back(v);
        for (int v = 9; v >= 0; v--) exp_trace.push_back(v);
        for (int v = 1; v <= 5; v++) exp_trace.push_back(v);
        for (int v = 4; v >= 0; v--) exp_trace.push_back(v);
        start_seq();
        busy_cycles = 0;
        full_cycles = 0;
        while (busy && busy_cycles < 100) begin
            if (busy_cycles < exp_trace.size())
                chk($sformatf("trace[%0d]", busy_cycles), 32'(counter), 32'(exp_trace[busy_cycles]));
            if (lamp == 16'hFFFF) full_cycles++;
            if (counter == 5'd16) chk("peak_cs_down", 32'(count_state), 32'd2);
            busy_cycles++;
            tick();
        end
        chk("busy_cycles", 32'(busy_cycles), 32'd53);
        chk("full_lamp_cycles", 32'(full_cycles), 32'd1);
        chk("end_cnt", 32'(counter), 32'd0);
        chk("end_cs", 32'(count_state), 32'd0);
        $display("full sequence: busy=%0d full=%0d", busy_cycles, full_cycles);

        // Flick held through UP1
        flick = 1'b1;
        tick();
        peak = 0;
        for (int n = 0; n < 40 && peak < 16; n++) begin
            if (counter == 5'd5 || counter == 5'd10)
                chk($sformatf("up1_flick_cs@%0d", counter), 32'(count_state), 32'd1);
            if (int'(counter) > peak) peak = int'(counter);
            if (peak < 16) tick();
        end
        flick = 1'b0;
        chk("up1_flick_peak", 32'(peak), 32'd16);
        wait_idle();
        $display("flick held in UP1: peak=%0d", peak);

        // Kickbacks in UP2 (cycle 33) and UP3 (cycle 58)
        start_seq();
        for (int c = 2; c <= 74; c++) begin
            tick();
            flick = (c == 33 || c == 58);
            #1;
            case (c)
                33: begin chk("kb2_cnt", 32'(counter), 32'd10); chk("kb2_cs", 32'(count_state), 32'd2); end
                38: chk("kb2_low", 32'(counter), 32'd5);
                43: begin chk("kb2_up_again", 32'(counter), 32'd10); chk("kb2_down2_cs", 32'(count_state), 32'd2); end
                53: begin chk("down2_zero", 32'(counter), 32'd0); chk("up3_cs", 32'(count_state), 32'd1); end
                58: begin chk("kb3_cnt", 32'(counter), 32'd5); chk("kb3_cs", 32'(count_state), 32'd2); end
                63: begin chk("kb3_zero", 32'(counter), 32'd0); chk("kb3_up3_cs", 32'(count_state), 32'd1); end
                68: begin chk("up3_again", 32'(counter), 32'd5); chk("down3_cs", 32'(count_state), 32'd2); end
                73: begin chk("down3_zero", 32'(counter), 32'd0); chk("down3_busy", 32'(busy), 32'd1); end
                74: chk("kb_end_busy", 32'(busy), 32'd0);
                default: ;
            endcase
        end
        flick = 1'b0;
        $display("kickback UP2/UP3 sequence done");

        // Out-of-range recovery in DOWN2 (cycle 36, counter 7)
        start_seq();
        for (int c = 2; c <= 36; c++) tick();
        chk("pre_force_cnt", 32'(counter), 32'd7);
        force_val = 5'd20;
        force_en = 1'b1;
        #1;
        chk("oor_load_en", 32'(counter_load_en), 32'd1);
        chk("oor_load", 32'(counter_load), 32'd0);
        chk("oor_lamp", 32'(lamp), 32'hFFFF);
        tick();
        force_en = 1'b0;
        #1;
        chk("oor_busy", 32'(busy), 32'd0);
        chk("oor_cnt", 32'(counter), 32'd0);
        chk("oor_load_en_off", 32'(counter_load_en), 32'd0);
        $display("out-of-range recovery done");

        // Reset mid-sequence in DOWN1 at counter 12 (cycle 21)
        tick();
        start_seq();
        for (int c = 2; c <= 21; c++) tick();
        chk("pre_rst_cnt", 32'(counter), 32'd12);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_lamp", 32'(lamp), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy", 32'(busy), 32'd0);
        start_seq();
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_cnt0", 32'(counter), 32'd0);
        tick();
        chk("restart_cnt1", 32'(counter), 32'd1);
        chk("restart_cs", 32'(count_state), 32'd1);
        $display("mid-sequence reset done");

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
